// File: rtl/pipe_stream_fifo_if.sv
// Handshake, payload and status bundle of the pixel-pipeline stream FIFO.
// The FIFO uses the slave view; a producer/consumer harness uses the master view.
interface pipe_stream_fifo_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3
);
    logic                  flush;
    logic                  clear_err;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [ADDR_WIDTH:0]   level;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, clear_err, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  flush, clear_err, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/pipe_stream_fifo.sv
// Single-clock first-word-fall-through stream FIFO for pixel words, full-capacity
// storage tracked by an occupancy counter; every output is driven from a register.
module pipe_stream_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1
) (
    input logic               clk_pipe,
    input logic               reset,
    pipe_stream_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);
    localparam logic [LW-1:0]         LVL_ONE  = LW'(1);
    localparam logic [LW-1:0]         LVL_ZERO = LW'(0);
    localparam logic [LW-1:0]         LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0]         LVL_AF   = LW'(AF_LEVEL);
    localparam logic [LW-1:0]         LVL_AE   = LW'(AE_LEVEL);

    generate
        if ((ADDR_WIDTH < 1) || (AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_params
            $error("pipe_stream_fifo: need ADDR_WIDTH>=1 and 0<=AE_LEVEL<AF_LEVEL<=DEPTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [LW-1:0]         level_r;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  almost_full_r;
    logic                  almost_empty_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  push_s;
    logic                  pop_s;
    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt_s;
    logic [LW-1:0]         level_nxt_s;
    logic [DATA_WIDTH-1:0] out_data_nxt_s;
    logic                  overflow_nxt_s;
    logic                  underflow_nxt_s;

    // Next-state of pointers, occupancy, head word and sticky error flags.
    always_comb begin
        push_s          = bus.in_valid & in_ready_r;
        pop_s           = out_valid_r & bus.out_ready;
        wr_en_s         = push_s & ~bus.flush;
        wr_ptr_nxt_s    = wr_ptr_r;
        rd_ptr_nxt_s    = rd_ptr_r;
        level_nxt_s     = level_r;
        out_data_nxt_s  = out_data_r;
        overflow_nxt_s  = overflow_r;
        underflow_nxt_s = underflow_r;

        if (bus.flush) begin
            wr_ptr_nxt_s = PTR_ZERO;
            rd_ptr_nxt_s = PTR_ZERO;
            level_nxt_s  = LVL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_nxt_s = level_r + LVL_ONE;
                2'b01:   level_nxt_s = level_r - LVL_ONE;
                default: level_nxt_s = level_r;
            endcase
        end

        // The head register must see a word written into the slot it is about to expose.
        if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            out_data_nxt_s = bus.in_data;
        end else begin
            out_data_nxt_s = mem_r[rd_ptr_nxt_s];
        end

        overflow_nxt_s  = (~bus.flush & bus.in_valid & ~in_ready_r) | (overflow_r & ~bus.clear_err);
        underflow_nxt_s = (~bus.flush & bus.out_ready & ~out_valid_r) | (underflow_r & ~bus.clear_err);
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk_pipe or negedge reset) begin
        if (!reset) begin
            wr_ptr_r       <= PTR_ZERO;
            rd_ptr_r       <= PTR_ZERO;
            level_r        <= LVL_ZERO;
            in_ready_r     <= 1'b1;
            out_valid_r    <= 1'b0;
            out_data_r     <= {DATA_WIDTH{1'b0}};
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            wr_ptr_r       <= wr_ptr_nxt_s;
            rd_ptr_r       <= rd_ptr_nxt_s;
            level_r        <= level_nxt_s;
            in_ready_r     <= (level_nxt_s != LVL_FULL);
            out_valid_r    <= (level_nxt_s != LVL_ZERO);
            out_data_r     <= out_data_nxt_s;
            almost_full_r  <= (level_nxt_s >= LVL_AF);
            almost_empty_r <= (level_nxt_s <= LVL_AE);
            overflow_r     <= overflow_nxt_s;
            underflow_r    <= underflow_nxt_s;
        end
    end

    // Payload storage; flush leaves contents in place.
    always_ff @(posedge clk_pipe or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= bus.in_data;
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_data     = out_data_r;
    assign bus.level        = level_r;
    assign bus.almost_full  = almost_full_r;
    assign bus.almost_empty = almost_empty_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_pipe_stream_fifo.sv
// Directed and randomised checks of pipe_stream_fifo against queue-based reference models
// for an 8x24 instance (default parameters) and a 16x16 instance.
module tb_pipe_stream_fifo;
    logic clk_pipe;
    logic reset;
    int   n_chk;
    int   n_err;

    pipe_stream_fifo_if #(.DATA_WIDTH(24), .ADDR_WIDTH(3)) b8 ();
    pipe_stream_fifo_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) b16 ();

    pipe_stream_fifo #(.DATA_WIDTH(24), .ADDR_WIDTH(3)) dut8 (
        .clk_pipe(clk_pipe), .reset(reset), .bus(b8)
    );
    pipe_stream_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(3)) dut16 (
        .clk_pipe(clk_pipe), .reset(reset), .bus(b16)
    );

    initial clk_pipe = 1'b0;
    always #5 clk_pipe = ~clk_pipe;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference contents and sticky flags of each instance.
    logic [23:0] q8 [$];
    logic [15:0] q16 [$];
    bit ovf8, udf8, ovf16, udf16;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc8(input logic iv, input logic [23:0] d, input logic ordy,
                        input logic fl, input logic ce);
        int sz;
        bit push, pop;
        b8.in_valid = iv; b8.in_data = d; b8.out_ready = ordy;
        b8.flush = fl; b8.clear_err = ce;
        sz   = q8.size();
        push = iv && (sz < 8);
        pop  = ordy && (sz > 0);
        ovf8 = (!fl && iv && sz == 8) || (ovf8 && !ce);
        udf8 = (!fl && ordy && sz == 0) || (udf8 && !ce);
        if (fl) begin
            q8.delete();
        end else begin
            if (pop) void'(q8.pop_front());
            if (push) q8.push_back(d);
        end
        @(posedge clk_pipe);
        #1;
        sz = q8.size();
        check("level8", 32'(b8.level), 32'(sz));
        check("in_ready8", 32'(b8.in_ready), 32'(sz != 8));
        check("out_valid8", 32'(b8.out_valid), 32'(sz != 0));
        check("almost_full8", 32'(b8.almost_full), 32'(sz >= 6));
        check("almost_empty8", 32'(b8.almost_empty), 32'(sz <= 1));
        check("overflow8", 32'(b8.overflow), 32'(ovf8));
        check("underflow8", 32'(b8.underflow), 32'(udf8));
        if (sz != 0) check("out_data8", 32'(b8.out_data), 32'(q8[0]));
    endtask

    task automatic cyc16(input logic iv, input logic [15:0] d, input logic ordy,
                         input logic fl, input logic ce);
        int sz;
        bit push, pop;
        b16.in_valid = iv; b16.in_data = d; b16.out_ready = ordy;
        b16.flush = fl; b16.clear_err = ce;
        sz    = q16.size();
        push  = iv && (sz < 16);
        pop   = ordy && (sz > 0);
        ovf16 = (!fl && iv && sz == 16) || (ovf16 && !ce);
        udf16 = (!fl && ordy && sz == 0) || (udf16 && !ce);
        if (fl) begin
            q16.delete();
        end else begin
            if (pop) void'(q16.pop_front());
            if (push) q16.push_back(d);
        end
        @(posedge clk_pipe);
        #1;
        sz = q16.size();
        check("level16", 32'(b16.level), 32'(sz));
        check("in_ready16", 32'(b16.in_ready), 32'(sz != 16));
        check("out_valid16", 32'(b16.out_valid), 32'(sz != 0));
        check("almost_full16", 32'(b16.almost_full), 32'(sz >= 12));
        check("almost_empty16", 32'(b16.almost_empty), 32'(sz <= 3));
        check("overflow16", 32'(b16.overflow), 32'(ovf16));
        check("underflow16", 32'(b16.underflow), 32'(udf16));
        if (sz != 0) check("out_data16", 32'(b16.out_data), 32'(q16[0]));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        b8.in_valid = 1'b0;  b8.in_data = 24'h0;  b8.out_ready = 1'b0;
        b8.flush = 1'b0;     b8.clear_err = 1'b0;
        b16.in_valid = 1'b0; b16.in_data = 16'h0; b16.out_ready = 1'b0;
        b16.flush = 1'b0;    b16.clear_err = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_pipe);
        #1;
        check("rst_level", 32'(b8.level), 32'd0);
        check("rst_in_ready", 32'(b8.in_ready), 32'd1);
        check("rst_out_valid", 32'(b8.out_valid), 32'd0);
        check("rst_almost_empty", 32'(b8.almost_empty), 32'd1);
        check("rst_almost_full", 32'(b8.almost_full), 32'd0);
        check("rst_out_data", 32'(b8.out_data), 32'd0);
        check("rst_flags", 32'({b8.overflow, b8.underflow}), 32'd0);
        check("rst_level16", 32'(b16.level), 32'd0);
        check("rst_almost_empty16", 32'(b16.almost_empty), 32'd1);
        reset = 1'b1;

        // Fill to capacity, then overflow attempt
        for (int i = 1; i <= 8; i++) cyc8(1'b1, 24'(i), 1'b0, 1'b0, 1'b0);
        check("fill_level", 32'(b8.level), 32'd8);
        check("fill_in_ready", 32'(b8.in_ready), 32'd0);
        check("fill_out_data", 32'(b8.out_data), 32'h000001);
        cyc8(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
        check("ovf_set", 32'(b8.overflow), 32'd1);
        check("ovf_level", 32'(b8.level), 32'd8);

        // Full with both sides active: only the pop happens
        cyc8(1'b1, 24'hFFFFFF, 1'b1, 1'b0, 1'b0);
        check("full_pop_only", 32'(b8.level), 32'd7);
        check("full_pop_head", 32'(b8.out_data), 32'h000002);

        // Drain in order, then underflow
        for (int i = 0; i < 7; i++) cyc8(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        check("drain_empty", 32'(b8.out_valid), 32'd0);
        cyc8(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        check("udf_set", 32'(b8.underflow), 32'd1);
        cyc8(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        check("clear_err", 32'({b8.overflow, b8.underflow}), 32'd0);

        // Set and clear in the same cycle: set wins
        cyc8(1'b0, 24'h0, 1'b1, 1'b0, 1'b1);
        check("set_beats_clear", 32'(b8.underflow), 32'd1);
        cyc8(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);

        // Empty push: visible one cycle later
        cyc8(1'b1, 24'h123456, 1'b0, 1'b0, 1'b0);
        check("latency_valid", 32'(b8.out_valid), 32'd1);
        check("latency_data", 32'(b8.out_data), 32'h123456);

        // Steady push/pop at level 4 with pointer wrap
        for (int i = 0; i < 3; i++) cyc8(1'b1, 24'(24'h100 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 3; i < 23; i++) begin
            cyc8(1'b1, 24'(24'h100 + i), 1'b1, 1'b0, 1'b0);
            check("steady_level", 32'(b8.level), 32'd4);
        end

        // Flush at level 5 with push and pop requested
        cyc8(1'b1, 24'h200, 1'b0, 1'b0, 1'b0);
        check("pre_flush_level", 32'(b8.level), 32'd5);
        cyc8(1'b1, 24'h201, 1'b1, 1'b1, 1'b0);
        check("flush_level", 32'(b8.level), 32'd0);
        check("flush_out_valid", 32'(b8.out_valid), 32'd0);
        check("flush_flags", 32'({b8.overflow, b8.underflow}), 32'd0);
        cyc8(1'b1, 24'hABCDEF, 1'b0, 1'b0, 1'b0);
        check("post_flush_data", 32'(b8.out_data), 32'hABCDEF);

        // Asynchronous reset mid-stream
        cyc8(1'b1, 24'h300, 1'b0, 1'b0, 1'b0);
        b8.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_level", 32'(b8.level), 32'd0);
        check("async_rst_valid", 32'(b8.out_valid), 32'd0);
        check("async_rst_data", 32'(b8.out_data), 32'd0);
        q8.delete();
        ovf8 = 1'b0;
        udf8 = 1'b0;
        @(posedge clk_pipe);
        #1;
        reset = 1'b1;
        cyc8(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);

        // Randomised traffic on the 16-deep instance: fill-biased, then drain-biased
        for (int i = 0; i < 1200; i++) begin
            int pin, pout;
            pin  = (i < 600) ? 70 : 35;
            pout = (i < 600) ? 40 : 75;
            cyc16(1'($urandom_range(0, 99) < pin), 16'($urandom),
                  1'($urandom_range(0, 99) < pout),
                  1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
